// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, BOOT/FETCH(/HOLD) sequencer and IF/ID handoff registers.
// Optional one-entry response buffer with HOLD state is enabled by defining IF_FETCH_BUFFER_EN.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_4,
    output logic [31:0] instruction,
    output logic        inst_valid,
    output logic        fetch_stall
);

`ifdef IF_FETCH_BUFFER_EN
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_4_q, pc_4_d;
    logic [31:0] instruction_q, instruction_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_aligned;

`ifdef IF_FETCH_BUFFER_EN
    logic [31:0] buf_q, buf_d;
`endif

    assign pc_plus4         = pc_q + 32'd4;
    assign redirect_aligned = {redirect_pc[31:2], 2'b00};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_4_d        = pc_4_q;
        instruction_d = instruction_q;
        inst_valid_d  = inst_valid_q;
`ifdef IF_FETCH_BUFFER_EN
        buf_d         = buf_q;
`endif
        imem_req      = 1'b0;
        fetch_stall   = 1'b1;

        case (state_q)
            BOOT: begin
                state_d = FETCH;
                if (redirect) begin
                    pc_d         = redirect_aligned;
                    inst_valid_d = 1'b0;
                end
            end

            FETCH: begin
                imem_req = 1'b1;
                if (redirect) begin
                    // Redirect wins over stall and discards any response this cycle.
                    pc_d         = redirect_aligned;
                    inst_valid_d = 1'b0;
                    fetch_stall  = 1'b0;
                end else if (!imem_ready) begin
                    inst_valid_d = 1'b0;
                end else if (pc_write) begin
                    pc_d          = pc_plus4;
                    pc_4_d        = pc_plus4;
                    instruction_d = imem_rdata;
                    inst_valid_d  = 1'b1;
                    fetch_stall   = 1'b0;
                end else begin
`ifdef IF_FETCH_BUFFER_EN
                    buf_d   = imem_rdata;
                    state_d = HOLD;
`endif
                    // Without the buffer the word is dropped and the same PC is re-requested.
                end
            end

`ifdef IF_FETCH_BUFFER_EN
            HOLD: begin
                if (redirect) begin
                    pc_d         = redirect_aligned;
                    inst_valid_d = 1'b0;
                    state_d      = FETCH;
                    fetch_stall  = 1'b0;
                end else if (pc_write) begin
                    pc_d          = pc_plus4;
                    pc_4_d        = pc_plus4;
                    instruction_d = buf_q;
                    inst_valid_d  = 1'b1;
                    state_d       = FETCH;
                    fetch_stall   = 1'b0;
                end
            end
`endif

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            pc_4_q        <= 32'h0;
            instruction_q <= 32'h0;
            inst_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_4_q        <= pc_4_d;
            instruction_q <= instruction_d;
            inst_valid_q  <= inst_valid_d;
        end
    end

`ifdef IF_FETCH_BUFFER_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            buf_q <= 32'h0;
        end else begin
            buf_q <= buf_d;
        end
    end
`endif

    assign imem_addr   = pc_q;
    assign pc_4        = pc_4_q;
    assign instruction = instruction_q;
    assign inst_valid  = inst_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: driver pushes expected deliveries, monitor pops and compares.
module tb_if_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        pc_write = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_ready = 1'b1;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc_4;
    logic [31:0] instruction;
    logic        inst_valid;
    logic        fetch_stall;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    logic [63:0] exp_q[$];
    logic        pw_last = 1'b0;

    if_fetch dut (
        .clock       (clock),
        .reset       (reset),
        .pc_write    (pc_write),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .pc_4        (pc_4),
        .instruction (instruction),
        .inst_valid  (inst_valid),
        .fetch_stall (fetch_stall)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Inputs change 2 time units after the rising edge, so they are stable at the next edge.
    task automatic step(input logic pw, input logic rdy, input logic rd,
                        input logic [31:0] rpc, input logic [31:0] rdata);
        @(posedge clock);
        #2;
        pc_write    = pw;
        imem_ready  = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        imem_rdata  = rdata;
        #1;
    endtask

    task automatic push(input logic [31:0] p4, input logic [31:0] word);
        exp_q.push_back({p4, word});
    endtask

    // A fresh delivery shows inst_valid=1 after a cycle driven with pc_write=1.
    initial begin : monitor
        logic [63:0] e;
        forever begin
            @(negedge clock);
            if (reset && pw_last && inst_valid) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL delivery: unexpected pc_4=%h instruction=%h", pc_4, instruction);
                end else begin
                    e = exp_q.pop_front();
                    if ({pc_4, instruction} !== e) begin
                        n_bad++;
                        $display("FAIL delivery: got pc_4=%h instruction=%h expected pc_4=%h instruction=%h",
                                 pc_4, instruction, e[63:32], e[31:0]);
                    end else begin
                        $display("ok   delivery: pc_4=%h instruction=%h", pc_4, instruction);
                    end
                end
            end
            pw_last = pc_write;
        end
    end

    task automatic boot_sequence();
        // Release reset; first cycle is BOOT.
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'hAAAA_0000);
        reset = 1'b1;
        #1;
        chk("boot_req", {31'd0, imem_req}, 32'd0);
        chk("boot_stall", {31'd0, fetch_stall}, 32'd1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h1111_0000);
        chk("f0_addr", imem_addr, 32'h0);
        chk("f0_req", {31'd0, imem_req}, 32'd1);
        push(32'h4, 32'h1111_0000);
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h1111_0004);
        chk("f1_addr", imem_addr, 32'h4);
        push(32'h8, 32'h1111_0004);
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h1111_0008);
        chk("f2_addr", imem_addr, 32'h8);
        push(32'hC, 32'h1111_0008);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        #3;
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_pc_4", pc_4, 32'h0);
        chk("rst_instruction", instruction, 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_fetch_stall", {31'd0, fetch_stall}, 32'd1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);

        boot_sequence();

        // PC = 0xC -> advance to 0x10.
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h2222_000C);
        chk("f3_addr", imem_addr, 32'hC);
        push(32'h10, 32'h2222_000C);

        // Three not-ready cycles at PC 0x10.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0, 32'hBAD0_0000);
            chk("wait_addr", imem_addr, 32'h10);
            chk("wait_stall", {31'd0, fetch_stall}, 32'd1);
            if (i > 0) chk("wait_valid", {31'd0, inst_valid}, 32'd0);
        end
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h3333_0010);
        chk("wait_done_valid", {31'd0, inst_valid}, 32'd0);
        chk("wait_done_addr", imem_addr, 32'h10);
        push(32'h14, 32'h3333_0010);

        // Redirect to misaligned target while a response is present.
        step(1'b1, 1'b1, 1'b1, 32'h0000_0103, 32'hDEAD_BEEF);
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h4444_0100);
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_bubble", {31'd0, inst_valid}, 32'd0);
        push(32'h104, 32'h4444_0100);

        // Move to 0x20, then stall with pc_write=0 for two cycles.
        step(1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h5555_0020);
        chk("stall_addr", imem_addr, 32'h20);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h5555_0020);
`ifdef IF_FETCH_BUFFER_EN
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        chk("hold_stall", {31'd0, fetch_stall}, 32'd1);
`else
        chk("refetch_addr", imem_addr, 32'h20);
        chk("refetch_req", {31'd0, imem_req}, 32'd1);
        chk("refetch_stall", {31'd0, fetch_stall}, 32'd1);
`endif
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h5555_0020);
        chk("resume_addr", imem_addr, 32'h20);
        push(32'h24, 32'h5555_0020);

        // PC wrap at the top of the address space.
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h6666_FFFC);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        push(32'h0, 32'h6666_FFFC);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("wrap_next_addr", imem_addr, 32'h0);

        // Reset pulsed in the middle of a fetch with a response present.
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'hBAD1_BAD1);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("mid_rst_pc_4", pc_4, 32'h0);
        chk("mid_rst_instruction", instruction, 32'h0);
        chk("mid_rst_addr", imem_addr, 32'h0);
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'hBAD2_BAD2);
        chk("mid_rst_held_valid", {31'd0, inst_valid}, 32'd0);

        boot_sequence();

        // Drain with no further deliveries.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
